bob_ctrl: RTL
=============

Name: bob_ctrl

Overview:
- Pointer/occupancy controller and misprediction-recovery sequencer for the 16-entry branch ordering buffer (dual-port RAM, 1-cycle registered read).
- Sits between fetch (allocation on predicted conditional/indirect branch) and retire (in-order dealloc).
- Drives RAM read/write indices and enables.
- On a mispredicted retire, reads the head snapshot, presents it to the predictor restore path, then flushes the front end and the buffer.

Parameters:
- DEPTH, 16, number of entries (power of two).
- LOGDEPTH, 4, log2(DEPTH); pointer width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- alloc_req_i  in  1  fetch requests an entry this cycle.
- alloc_gnt_o  out  1  entry granted; RAM write occurs this cycle.
- wr_idx_o  out  LOGDEPTH  RAM write index (tail pointer).
- wr_en_o  out  1  RAM write enable (= alloc_gnt_o).
- retire_vld_i  in  1  a conditional/indirect branch retires.
- retire_mispred_i  in  1  the retiring branch was mispredicted (qualified by retire_vld_i).
- rd_idx_o  out  LOGDEPTH  RAM read index (head pointer, or captured index in recovery).
- head_vld_o  out  1  buffer non-empty.
- restore_vld_o  out  1  RAM read data holds the snapshot to restore; 1-cycle pulse.
- flush_o  out  1  front-end flush; 1-cycle pulse.
- stall_o  out  1  fetch must hold (full, or recovery in progress).
- count_o  out  LOGDEPTH+1  occupancy, 0..DEPTH.
- err_underflow_o  out  1  sticky: retire seen while empty.

Behaviour:
- State: head, tail (LOGDEPTH bits, wrap modulo DEPTH), count (LOGDEPTH+1 bits), FSM state, cap_idx.
- Reset (sync, highest priority, also mid-recovery):
  - head = tail = count = 0; FSM = RUN; err_underflow_o = 0.
  - All pulse outputs 0; stall_o = 0; head_vld_o = 0.
- FSM states: RUN, RDWAIT, RESTORE, FLUSH.
- RUN:
  - alloc_gnt_o = alloc_req_i & ~full, where full = (count == DEPTH).
  - On grant: tail <= tail+1 (wraps 15 -> 0).
  - rd_idx_o = head.
  - Retire with count > 0 and no mispredict: head <= head+1.
  - Simultaneous grant and retire: both pointers advance; count unchanged.
  - Retire with count == 0: no pointer change; err_underflow_o <= 1.
  - Retire with mispredict and count > 0: cap_idx <= head; go to RDWAIT. Any same-cycle alloc is denied (alloc_gnt_o forced 0).
- RDWAIT: rd_idx_o = cap_idx; RAM read in flight; alloc_gnt_o = 0; retire ignored.
- RESTORE: rd_idx_o = cap_idx; restore_vld_o = 1 for exactly this cycle; alloc_gnt_o = 0.
- FLUSH:
  - flush_o = 1 for one cycle.
  - head, tail, count <= 0 at the end of the cycle; next state RUN.
- Recovery latency: mispredicted retire at cycle N -> restore_vld_o at N+2 -> flush_o at N+3 -> alloc can be granted from N+4.
- stall_o = full | (state != RUN). It is combinational from registered state.
- head_vld_o = (count != 0) and is 0 outside RUN.
- count_o reflects registered count.
- Inputs during RDWAIT, RESTORE and FLUSH other than reset are ignored.

Optional Feature:
- Macro: BOB_CTRL_FULL_BYPASS_EN.
- Defined: when full, an alloc is granted if a non-mispredicted retire occurs in the same cycle. The write goes to the slot freed by head; count stays DEPTH. In this case stall_o = full & ~(retire_vld_i & ~retire_mispred_i).
- Undefined: alloc is never granted while full, and stall_o = full.

Test Plan:
- Reset then 16 allocs, no retires -> wr_idx_o 0..15; count_o = 16; stall_o = 1; 17th req gets alloc_gnt_o = 0.
- From full, 16 retires then 3 allocs -> head wraps to 0; tail sequence 0,1,2; count_o = 3; head_vld_o = 1.
- count = 5, alloc and retire in the same cycle for 10 cycles -> count_o stays 5; head and tail both advance by 10 (mod 16).
- count = 4, head = 2, mispredicted retire at cycle N:
  - rd_idx_o = 2 at N+1 and N+2; restore_vld_o = 1 at N+2 only; flush_o = 1 at N+3.
  - count_o = 0 at N+4; alloc requests during N..N+3 are denied.
- Retire while empty -> err_underflow_o = 1 and stays sticky; pointers unchanged.
- Assert reset during RESTORE -> next cycle state RUN, restore_vld_o = 0, flush_o = 0, count_o = 0.
- Full plus same-cycle clean retire and alloc -> grant only with BOB_CTRL_FULL_BYPASS_EN (count_o stays 16); denied without it.

Source files
------------

// File: rtl/bob_ctrl_if.sv
// Fetch/retire/RAM-index bundle for the branch ordering buffer controller.
// The controller takes the slave modport; the surrounding pipeline drives the master side.
interface bob_ctrl_if #(
    parameter int LOGDEPTH = 4
);
    logic                alloc_req_i;
    logic                alloc_gnt_o;
    logic [LOGDEPTH-1:0] wr_idx_o;
    logic                wr_en_o;
    logic                retire_vld_i;
    logic                retire_mispred_i;
    logic [LOGDEPTH-1:0] rd_idx_o;
    logic                head_vld_o;
    logic                restore_vld_o;
    logic                flush_o;
    logic                stall_o;
    logic [LOGDEPTH:0]   count_o;
    logic                err_underflow_o;

    modport slave (
        input  alloc_req_i, retire_vld_i, retire_mispred_i,
        output alloc_gnt_o, wr_idx_o, wr_en_o, rd_idx_o, head_vld_o,
               restore_vld_o, flush_o, stall_o, count_o, err_underflow_o
    );

    modport master (
        output alloc_req_i, retire_vld_i, retire_mispred_i,
        input  alloc_gnt_o, wr_idx_o, wr_en_o, rd_idx_o, head_vld_o,
               restore_vld_o, flush_o, stall_o, count_o, err_underflow_o
    );
endinterface

// File: rtl/bob_ctrl.sv
// Branch ordering buffer pointer/occupancy controller with misprediction recovery sequencer.
// Optional BOB_CTRL_FULL_BYPASS_EN: grant an alloc while full when a clean retire frees the head slot.
module bob_ctrl #(
    parameter int DEPTH    = 16,
    parameter int LOGDEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    bob_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {RUN, RDWAIT, RESTORE, FLUSH} state_t;

    state_t              state;
    logic [LOGDEPTH-1:0] head;
    logic [LOGDEPTH-1:0] tail;
    logic [LOGDEPTH-1:0] cap_idx;
    logic [LOGDEPTH:0]   count;
    logic                err_underflow;

    logic full;
    logic in_run;
    logic retire_ok;
    logic mispred;
    logic clean_retire;
    logic bypass_ok;
    logic alloc_gnt;

    always_comb begin
        full         = (count == (LOGDEPTH+1)'(DEPTH));
        in_run       = (state == RUN);
        retire_ok    = in_run & bus.retire_vld_i & (count != '0);
        mispred      = retire_ok & bus.retire_mispred_i;
        clean_retire = retire_ok & ~bus.retire_mispred_i;
`ifdef BOB_CTRL_FULL_BYPASS_EN
        bypass_ok    = clean_retire;
`else
        bypass_ok    = 1'b0;
`endif
        // A mispredicting retire blocks allocation: the slot would be flushed anyway.
        alloc_gnt    = in_run & bus.alloc_req_i & ~mispred & (~full | bypass_ok);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= RUN;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            err_underflow <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (alloc_gnt)
                        tail <= tail + 1'b1;
                    if (clean_retire)
                        head <= head + 1'b1;
                    if (bus.retire_vld_i && count == '0)
                        err_underflow <= 1'b1;
                    case ({alloc_gnt, clean_retire})
                        2'b10:   count <= count + 1'b1;
                        2'b01:   count <= count - 1'b1;
                        default: count <= count;
                    endcase
                    if (mispred)
                        state <= RDWAIT;
                end
                RDWAIT:  state <= RESTORE;
                RESTORE: state <= FLUSH;
                FLUSH: begin
                    head  <= '0;
                    tail  <= '0;
                    count <= '0;
                    state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    // Captured head index steers the RAM read for the whole recovery sequence.
    always_ff @(posedge clock) begin
        if (mispred)
            cap_idx <= head;
    end

    assign bus.alloc_gnt_o     = alloc_gnt;
    assign bus.wr_en_o         = alloc_gnt;
    assign bus.wr_idx_o        = tail;
    assign bus.rd_idx_o        = in_run ? head : cap_idx;
    assign bus.head_vld_o      = in_run & (count != '0);
    assign bus.restore_vld_o   = (state == RESTORE);
    assign bus.flush_o         = (state == FLUSH);
    assign bus.stall_o         = (full & ~bypass_ok) | ~in_run;
    assign bus.count_o         = count;
    assign bus.err_underflow_o = err_underflow;
endmodule
